// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage: PC register, instruction-memory address drive and
//   the IF/ID pipeline register. Honours the hazard unit's pc_stall / nop
//   controls and the execute-stage redirect. A small RUN/HALTED FSM stops fetch
//   once a HALT word has been fetched until a redirect or reset arrives.
//
// Ports
//   clk          in   1   clock, all state on rising edge
//   rst          in   1   asynchronous active-low reset
//   imem_addr    out  16  instruction-memory address (= PC register)
//   imem_data    in   16  instruction word at imem_addr (async read)
//   pc_stall     in   1   hold PC and IF/ID
//   nop          in   1   load a bubble into IF/ID, PC holds
//   redirect_en  in   1   taken branch/jump from downstream
//   redirect_pc  in   16  redirect target
//   if_instr     out  16  IF/ID instruction
//   if_pc_plus2  out  16  IF/ID PC+2 of if_instr
//   if_valid     out  1   1 = real instruction, 0 = bubble
//   halted       out  1   FSM is in HALTED
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        pc_stall,
  input  logic        nop,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_plus2,
  output logic        if_valid,
  output logic        halted
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pcp2_q, pcp2_d;
  logic        valid_q, valid_d;
  logic [15:0] pc_plus2_s;

  // 16-bit wrap-around increment; FFFE + 2 = 0000 with the carry dropped.
  assign pc_plus2_s = pc_q + 16'd2;

  // Next-state selection in fixed priority: redirect, halted, stall, nop, advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp2_d  = pcp2_q;
    valid_d = valid_q;
    if (redirect_en) begin
      // Redirect wins over everything, including HALTED: the HALT was speculative.
      pc_d    = redirect_pc;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (state_q == ST_HALTED) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (pc_stall) begin
      // Full hold: nop is ignored while stalled.
      instr_d = instr_q;
    end else if (nop) begin
      // PC holds so the same address is refetched after the bubble.
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus2_s;
      instr_d = imem_data;
      pcp2_d  = pc_plus2_s;
      valid_d = 1'b1;
      if (imem_data[15:11] == HALT_OPC) begin
        state_d = ST_HALTED;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  // State and pipeline registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp2_q  <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp2_q  <= pcp2_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_instr    = instr_q;
  assign if_pc_plus2 = pcp2_q;
  assign if_valid    = valid_q;
  assign halted      = (state_q == ST_HALTED);

endmodule
